// File: rtl/resp_tx_queue.sv
// resp_tx_queue: response FIFO + byte serializer feeding a UART transmitter.
// Ports:
//   clk, rst_n (sync, active-low)
//   send_resp/resp_cmd/resp_data: push a {cmd,data} response
//   full, empty, busy, ovfl (sticky), clr_ovfl
//   resp_sent: pulse after the last byte of a response completes
//   trmt/tx_data/tx_done: transmitter handshake
// Optional: define RESP_CHKSUM_EN to append ~(cmd+d_hi+d_lo) as a 4th byte.
module resp_tx_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send_resp,
    input  logic [7:0]  resp_cmd,
    input  logic [15:0] resp_data,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic        ovfl,
    input  logic        clr_ovfl,
    output logic        resp_sent,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef RESP_CHKSUM_EN
    localparam int SW = 32;
    localparam logic [1:0] LAST = 2'd3;
`else
    localparam int SW = 24;
    localparam logic [1:0] LAST = 2'd2;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state, state_nxt;

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] shreg;
    logic [SW-1:0] head;
    logic [1:0]    byte_cnt;
    logic          push, pop, byte_done;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign busy  = (state != IDLE);

    // A push while full is lost even if a pop happens on the same edge.
    assign push      = send_resp & ~full;
    assign pop       = (state == IDLE) & ~empty;
    assign byte_done = (state == WAIT) & tx_done;

`ifdef RESP_CHKSUM_EN
    logic [7:0] chk_sum;
    assign chk_sum = mem[rd_ptr][23:16] + mem[rd_ptr][15:8] + mem[rd_ptr][7:0];
    assign head    = {mem[rd_ptr], ~chk_sum};
`else
    assign head = mem[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {resp_cmd, resp_data};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (tx_done) state_nxt = (byte_cnt == LAST) ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovfl      <= 1'b0;
            shreg     <= '0;
            byte_cnt  <= '0;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
            resp_sent <= 1'b0;
        end else begin
            state     <= state_nxt;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);

            if (send_resp && full)
                ovfl <= 1'b1;
            else if (clr_ovfl)
                ovfl <= 1'b0;

            // trmt/tx_data are loaded on the edge entering ISSUE so they
            // line up with the ISSUE cycle without combinational outputs.
            if (pop) begin
                shreg    <= head;
                byte_cnt <= '0;
                trmt     <= 1'b1;
                tx_data  <= head[SW-1 -: 8];
            end

            if (byte_done) begin
                shreg    <= shreg << 8;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == LAST) begin
                    resp_sent <= 1'b1;
                end else begin
                    trmt    <= 1'b1;
                    tx_data <= shreg[SW-9 -: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_resp_tx_queue.sv
// tb_resp_tx_queue: randomized scoreboard bench for resp_tx_queue.
// Reference model: byte queue + entry count; transmitter model with delay.
module tb_resp_tx_queue;

    localparam int DEPTH = 4;
`ifdef RESP_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp_cmd = 8'h00;
    logic [15:0] resp_data = 16'h0000;
    logic        clr_ovfl = 1'b0;
    logic        tx_done = 1'b0;
    logic        full, empty, busy, ovfl, resp_sent, trmt;
    logic [7:0]  tx_data;

    resp_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (send_resp),
        .resp_cmd  (resp_cmd),
        .resp_data (resp_data),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .ovfl      (ovfl),
        .clr_ovfl  (clr_ovfl),
        .resp_sent (resp_sent),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         nchk = 0;
    int         nfail = 0;
    logic [7:0] exp_q[$];
    int         model_count = 0;
    bit         model_ovfl = 0;
    int         tx_delay = 20;
    bit         tx_stall = 0;
    int         tx_cnt = 0;
    int         trmt_total = 0;
    int         resp_total = 0;
    int         last_trmt_cyc = 0;
    bit         outstanding = 0;
    int         pos = 0;
    logic [7:0] cur_exp = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        nchk++;
        nfail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Transmitter: drops tx_done when it sees trmt, raises it after tx_delay.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (trmt === 1'b1) begin
                tx_done = 1'b0;
                tx_cnt  = tx_delay;
            end else if (tx_cnt > 0 && !tx_stall) begin
                tx_cnt--;
                if (tx_cnt == 0)
                    tx_done = 1'b1;
            end
        end
    end

    // Monitor: checks bytes, handshake timing and flags against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 0;
                pos = 0;
            end else begin
                if (outstanding && tx_done) begin
                    if (pos == 0) begin
                        check("resp_sent_after_last", 32'(resp_sent), 1);
                        check("no_trmt_after_last", 32'(trmt), 0);
                    end else begin
                        check("trmt_next_byte", 32'(trmt), 1);
                        check("no_resp_sent_mid", 32'(resp_sent), 0);
                    end
                    outstanding = 0;
                end else if (resp_sent) begin
                    fail_now("resp_sent_spurious");
                end
                if (resp_sent)
                    resp_total++;
                if (trmt) begin
                    if (outstanding)
                        fail_now("trmt_before_tx_done");
                    if (exp_q.size() == 0) begin
                        fail_now("trmt_unexpected");
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("tx_data", 32'(tx_data), 32'(cur_exp));
                        if (pos == 0 && model_count > 0)
                            model_count--;
                    end
                    pos = (pos + 1) % NB;
                    outstanding = 1;
                    trmt_total++;
                    last_trmt_cyc = cyc;
                end else if (outstanding) begin
                    check("tx_data_hold", 32'(tx_data), 32'(cur_exp));
                end
                check("full", 32'(full), 32'(model_count == DEPTH));
                check("empty", 32'(empty), 32'(model_count == 0));
                check("ovfl", 32'(ovfl), 32'(model_ovfl));
            end
        end
    end

    task automatic drive(input bit do_push, input logic [7:0] c,
                         input logic [15:0] d, input bit do_clr);
        logic [7:0] s;
        send_resp = do_push;
        resp_cmd  = c;
        resp_data = d;
        clr_ovfl  = do_clr;
        if (do_push && model_count == DEPTH) begin
            model_ovfl = 1;
        end else begin
            if (do_clr)
                model_ovfl = 0;
            if (do_push) begin
                model_count++;
                exp_q.push_back(c);
                exp_q.push_back(d[15:8]);
                exp_q.push_back(d[7:0]);
                s = c + d[15:8] + d[7:0];
                if (NB == 4)
                    exp_q.push_back(~s);
            end
        end
        step();
        send_resp = 1'b0;
        clr_ovfl  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || outstanding) && t < 5000) begin
            step();
            t++;
        end
        if (t >= 5000)
            fail_now("drain_timeout");
        step();
        check("drain_busy", 32'(busy), 0);
        check("drain_empty", 32'(empty), 1);
    endtask

    task automatic wait_trmts(input int target);
        int t;
        t = 0;
        while (trmt_total < target && t < 200) begin
            step();
            t++;
        end
        if (t >= 200)
            fail_now("trmt_timeout");
    endtask

    int c0, t0, r0;

    initial begin
        repeat (3) step();
        rst_n = 1'b1;

        repeat (100) step();
        check("idle_trmt_count", 32'(trmt_total), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_resp_sent_count", 32'(resp_total), 0);

        tx_delay = 20;
        t0 = trmt_total;
        r0 = resp_total;
        c0 = cyc;
        drive(1, 8'hA5, 16'h1234, 0);
        wait_trmts(t0 + 1);
        check("first_trmt_latency", 32'(last_trmt_cyc - c0), 2);
        drain();
        check("single_trmt_count", 32'(trmt_total - t0), NB);
        check("single_resp_count", 32'(resp_total - r0), 1);

        tx_stall = 1;
        tx_delay = 3;
        t0 = trmt_total;
        for (int i = 0; i < DEPTH + 2; i++)
            drive(1, 8'($urandom), 16'($urandom), 0);
        check("ovfl_set", 32'(ovfl), 1);
        check("full_set", 32'(full), 1);
        tx_stall = 0;
        drain();
        check("ovfl_burst_bytes", 32'(trmt_total - t0), (DEPTH + 1) * NB);
        drive(0, 8'h00, 16'h0000, 1);
        check("ovfl_cleared", 32'(ovfl), 0);

        tx_delay = 8;
        t0 = trmt_total;
        r0 = resp_total;
        drive(1, 8'h3C, 16'hBEEF, 0);
        wait_trmts(t0 + 2);
        repeat (2) step();
        drive(1, 8'h5A, 16'hC0DE, 0);
        drain();
        check("overlap_trmt_count", 32'(trmt_total - t0), 2 * NB);
        check("overlap_resp_count", 32'(resp_total - r0), 2);

        tx_stall = 1;
        drive(1, 8'h11, 16'h2233, 0);
        drive(1, 8'h44, 16'h5566, 0);
        drive(1, 8'h77, 16'h8899, 0);
        repeat (5) step();
        rst_n = 1'b0;
        exp_q.delete();
        model_count = 0;
        model_ovfl = 0;
        step();
        check("rst_busy", 32'(busy), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_trmt", 32'(trmt), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        rst_n = 1'b1;
        tx_stall = 0;
        t0 = trmt_total;
        repeat (30) step();
        check("post_rst_no_trmt", 32'(trmt_total - t0), 0);
        drive(1, 8'h01, 16'h0002, 0);
        drain();
        check("post_rst_bytes", 32'(trmt_total - t0), NB);

        for (int i = 0; i < 400; i++) begin
            tx_delay = $urandom_range(1, 6);
            drive($urandom_range(0, 2) == 0, 8'($urandom), 16'($urandom),
                  $urandom_range(0, 15) == 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
